// File: rtl/md_pkg.sv
// ---------------------------------------------------------------------------
// md_pkg
// Definitions shared by the HI/LO multiply/divide control block and its
// parent: the 3-bit EX-stage operation code, the control FSM state encoding,
// and a decode helper.
// ---------------------------------------------------------------------------
package md_pkg;

    localparam int MD_DATA_W = 32;

    typedef enum logic [2:0] {
        OP_NOP  = 3'd0,
        OP_MULT = 3'd1,
        OP_DIV  = 3'd2,
        OP_MTHI = 3'd3,
        OP_MTLO = 3'd4,
        OP_MFHI = 3'd5,
        OP_MFLO = 3'd6,
        OP_RSVD = 3'd7
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MUL_WAIT = 2'd1,
        ST_DIV_WAIT = 2'd2
    } md_state_e;

    // True for every op that touches HI/LO or the arithmetic units; these
    // are the ops that must wait while a multiply or divide is in flight.
    function automatic logic is_md_op(input md_op_e o);
        case (o)
            OP_MULT, OP_DIV, OP_MTHI, OP_MTLO, OP_MFHI, OP_MFLO: return 1'b1;
            default:                                             return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/hilo_ctrl.sv
// ---------------------------------------------------------------------------
// hilo_ctrl
// Owns the architectural HI/LO registers and sequences the external
// multiplier and divider for MULT/DIV. MTHI/MTLO write HI/LO directly,
// MFHI/MFLO read them combinationally. While a multiply or divide is
// outstanding, any HI/LO-class op in EX is stalled through md_stall.
//
// Ports
//   clk, reset             clock; asynchronous active-high reset
//   op_valid, op           EX-stage instruction present / operation code
//   rs_val, rt_val         forwarded operands
//   ext_stall              stall from every other pipeline source
//   md_stall               stall request to the hazard unit
//   rdata                  MFHI/MFLO result
//   mul_start/a/b          multiplier start pulse and held operands
//   mul_z, mul_finish      multiplier product and valid pulse
//   mul_hold               multiplier freeze
//   div_start/a/b          divider start pulse and held operands
//   div_q, div_r           divider quotient and remainder
//   div_finish             divider valid pulse
//   hi, lo                 architectural HI/LO
// ---------------------------------------------------------------------------
module hilo_ctrl
    import md_pkg::*;
#(
    parameter int DATA_W = MD_DATA_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     op_valid,
    input  md_op_e                   op,
    input  logic [DATA_W-1:0]        rs_val,
    input  logic [DATA_W-1:0]        rt_val,
    input  logic                     ext_stall,
    output logic                     md_stall,
    output logic [DATA_W-1:0]        rdata,
    output logic                     mul_start,
    output logic signed [DATA_W-1:0] mul_a,
    output logic signed [DATA_W-1:0] mul_b,
    input  logic [2*DATA_W-1:0]      mul_z,
    input  logic                     mul_finish,
    output logic                     mul_hold,
    output logic                     div_start,
    output logic signed [DATA_W-1:0] div_a,
    output logic signed [DATA_W-1:0] div_b,
    input  logic [DATA_W-1:0]        div_q,
    input  logic [DATA_W-1:0]        div_r,
    input  logic                     div_finish,
    output logic [DATA_W-1:0]        hi,
    output logic [DATA_W-1:0]        lo
);

    md_state_e                state, state_nxt;
    logic                     fire;
    logic [DATA_W-1:0]        hi_nxt, lo_nxt;
    logic signed [DATA_W-1:0] mul_a_p1, mul_b_p1, div_a_p1, div_b_p1;

    // ---- EX stage: decode, stall, start and HI/LO write selection ----
    always_comb begin
        state_nxt = state;
        md_stall  = 1'b0;
        fire      = 1'b0;
        mul_start = 1'b0;
        div_start = 1'b0;
        hi_nxt    = hi;
        lo_nxt    = lo;

        // The finish cycle itself still stalls: HI/LO are only written at
        // its closing edge, so the reader gets them one cycle later.
        md_stall = op_valid && is_md_op(op) && (state != ST_IDLE);
        fire     = op_valid && !ext_stall && !md_stall;

        case (state)
            ST_IDLE: begin
                if (fire) begin
                    case (op)
                        OP_MULT: begin
                            mul_start = 1'b1;
                            state_nxt = ST_MUL_WAIT;
                        end
                        OP_DIV: begin
                            div_start = 1'b1;
                            state_nxt = ST_DIV_WAIT;
                        end
                        OP_MTHI: hi_nxt = rs_val;
                        OP_MTLO: lo_nxt = rs_val;
                        default: ;
                    endcase
                end
            end
            ST_MUL_WAIT: begin
                if (mul_finish) begin
                    hi_nxt    = mul_z[2*DATA_W-1:DATA_W];
                    lo_nxt    = mul_z[DATA_W-1:0];
                    state_nxt = ST_IDLE;
                end
            end
            ST_DIV_WAIT: begin
                // Divide-by-zero results pass through exactly as produced.
                if (div_finish) begin
                    hi_nxt    = div_r;
                    lo_nxt    = div_q;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        // Starts are outputs of the combinational path; keep them quiet
        // while reset is held so no unit is kicked during reset.
        if (reset) begin
            mul_start = 1'b0;
            div_start = 1'b0;
        end
    end

    always_comb begin
        rdata = '0;
        case (op)
            OP_MFHI: rdata = hi;
            OP_MFLO: rdata = lo;
            default: rdata = '0;
        endcase
    end

    // The multiplier freezes only for outside stalls; freezing it on our
    // own md_stall would stop the very operation md_stall waits on.
    assign mul_hold = ext_stall;

    // Operands are presented straight from rs/rt in the start cycle and
    // from the holding registers for the rest of the operation.
    assign mul_a = mul_start ? $signed(rs_val) : mul_a_p1;
    assign mul_b = mul_start ? $signed(rt_val) : mul_b_p1;
    assign div_a = div_start ? $signed(rs_val) : div_a_p1;
    assign div_b = div_start ? $signed(rt_val) : div_b_p1;

    // ---- Stage boundary: FSM state register ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // ---- Stage boundary: HI/LO and operand holding registers ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi       <= '0;
            lo       <= '0;
            mul_a_p1 <= '0;
            mul_b_p1 <= '0;
            div_a_p1 <= '0;
            div_b_p1 <= '0;
        end else begin
            hi <= hi_nxt;
            lo <= lo_nxt;
            if (mul_start) begin
                mul_a_p1 <= $signed(rs_val);
                mul_b_p1 <= $signed(rt_val);
            end
            if (div_start) begin
                div_a_p1 <= $signed(rs_val);
                div_b_p1 <= $signed(rt_val);
            end
        end
    end

endmodule

// File: tb/tb_hilo_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hilo_ctrl
// Bench for hilo_ctrl with behavioural multiplier (32 non-held cycles) and
// divider (8 cycles) units. Expected HI/LO pairs are queued when MULT/DIV is
// issued and compared after the matching finish edge.
// ---------------------------------------------------------------------------
module tb_hilo_ctrl;
    import md_pkg::*;

    localparam int DIV_LAT = 8;

    logic               clk = 1'b0;
    logic               reset;
    logic               op_valid;
    md_op_e             op;
    logic [31:0]        rs_val, rt_val;
    logic               ext_stall;
    logic               md_stall;
    logic [31:0]        rdata;
    logic               mul_start;
    logic signed [31:0] mul_a, mul_b;
    logic [63:0]        mul_z;
    logic               mul_finish;
    logic               mul_hold;
    logic               div_start;
    logic signed [31:0] div_a, div_b;
    logic [31:0]        div_q, div_r;
    logic               div_finish;
    logic [31:0]        hi, lo;

    hilo_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .op_valid   (op_valid),
        .op         (op),
        .rs_val     (rs_val),
        .rt_val     (rt_val),
        .ext_stall  (ext_stall),
        .md_stall   (md_stall),
        .rdata      (rdata),
        .mul_start  (mul_start),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_z      (mul_z),
        .mul_finish (mul_finish),
        .mul_hold   (mul_hold),
        .div_start  (div_start),
        .div_a      (div_a),
        .div_b      (div_b),
        .div_q      (div_q),
        .div_r      (div_r),
        .div_finish (div_finish),
        .hi         (hi),
        .lo         (lo)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---- behavioural multiplier: finishes after 32 non-held cycles ----
    logic        m_busy = 1'b0;
    int          m_cnt  = 0;
    logic [63:0] m_prod = '0;
    logic        spur_mul = 1'b0;

    always @(posedge clk) begin
        if (mul_start) begin
            m_busy <= 1'b1;
            m_cnt  <= 0;
            m_prod <= $signed({{32{mul_a[31]}}, mul_a}) * $signed({{32{mul_b[31]}}, mul_b});
        end else if (m_busy && !mul_hold) begin
            if (m_cnt == 31) m_busy <= 1'b0;
            else             m_cnt  <= m_cnt + 1;
        end
    end
    assign mul_z      = m_prod;
    assign mul_finish = (m_busy && m_cnt == 31 && !mul_hold) || spur_mul;

    // ---- behavioural divider: finishes DIV_LAT cycles after start ----
    logic        d_busy = 1'b0;
    int          d_cnt  = 0;
    logic [31:0] d_q = '0, d_r = '0;

    always @(posedge clk) begin
        if (div_start) begin
            d_busy <= 1'b1;
            d_cnt  <= 0;
            if (div_b == 0) begin
                d_q <= 32'hFFFF_FFFF;
                d_r <= div_a;
            end else begin
                d_q <= div_a / div_b;
                d_r <= div_a % div_b;
            end
        end else if (d_busy) begin
            if (d_cnt == DIV_LAT - 1) d_busy <= 1'b0;
            else                      d_cnt  <= d_cnt + 1;
        end
    end
    assign div_q      = d_q;
    assign div_r      = d_r;
    assign div_finish = d_busy && d_cnt == DIV_LAT - 1;

    // ---- scoreboard ----
    typedef struct {
        logic        is_div;
        logic [31:0] hi;
        logic [31:0] lo;
    } sb_t;
    sb_t sb[$];
    sb_t mon_e;

    always @(negedge clk) begin
        if (sb.size() > 0 &&
            ((sb[0].is_div && div_finish) || (!sb[0].is_div && mul_finish))) begin
            mon_e = sb.pop_front();
            @(posedge clk);
            #1;
            check_val(mon_e.is_div ? "div_hi" : "mul_hi", hi, mon_e.hi);
            check_val(mon_e.is_div ? "div_lo" : "mul_lo", lo, mon_e.lo);
        end
    end

    // Divide table: dividend, divisor, expected HI (remainder), LO (quotient)
    logic [31:0] dv_a  [3] = '{32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFFB};
    logic [31:0] dv_b  [3] = '{32'd7,   32'd2,         32'd0};
    logic [31:0] dv_hi [3] = '{32'd2,   32'hFFFF_FFFF, 32'hFFFF_FFFB};
    logic [31:0] dv_lo [3] = '{32'd14,  32'hFFFF_FFFD, 32'hFFFF_FFFF};

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    int n, k, fin_k, ds_k, ds_cnt, ms_cnt, stalls;
    logic fin;

    initial begin
        reset = 1'b1; op_valid = 1'b1; op = OP_MULT;
        rs_val = 32'd1; rt_val = 32'd1; ext_stall = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("rst_hi", hi, 32'd0);
        check_val("rst_lo", lo, 32'd0);
        check_val("rst_md_stall", md_stall, 1'b0);
        check_val("rst_mul_start", mul_start, 1'b0);
        check_val("rst_div_start", div_start, 1'b0);
        op_valid = 1'b0;
        reset = 1'b0;

        // MULT 7 * -3, then MFLO one cycle later
        tick();
        op_valid = 1'b1; op = OP_MULT; rs_val = 32'd7; rt_val = 32'hFFFF_FFFD;
        sb.push_back('{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFEB});
        @(negedge clk);
        check_val("mul_start_pulse", mul_start, 1'b1);
        check_val("mul_a_start", mul_a, 32'd7);
        check_val("mul_b_start", mul_b, 32'hFFFF_FFFD);
        tick();
        op = OP_MFLO; rs_val = 32'd0; rt_val = 32'd0;
        @(negedge clk);
        check_val("mul_start_single", mul_start, 1'b0);
        check_val("mul_a_held", mul_a, 32'd7);
        check_val("mul_b_held", mul_b, 32'hFFFF_FFFD);
        n = 0;
        while (md_stall === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        check_val("mflo_stall_cycles", n, 32'd32);
        check_val("mflo_rdata", rdata, 32'hFFFF_FFEB);
        tick();
        op_valid = 1'b0;

        // DIV table, MFHI waits, then MFLO; a stray mul_finish in DIV_WAIT
        for (int i = 0; i < 3; i++) begin
            tick();
            op_valid = 1'b1; op = OP_DIV; rs_val = dv_a[i]; rt_val = dv_b[i];
            sb.push_back('{1'b1, dv_hi[i], dv_lo[i]});
            @(negedge clk);
            check_val("div_start_pulse", div_start, 1'b1);
            check_val("div_a_start", div_a, dv_a[i]);
            check_val("div_b_start", div_b, dv_b[i]);
            tick();
            op = OP_MFHI;
            @(negedge clk);
            n = 0;
            while (md_stall === 1'b1 && n < 100) begin
                n++;
                spur_mul = (i == 0 && n == 2);
                @(negedge clk);
            end
            spur_mul = 1'b0;
            check_val("mfhi_stall_cycles", n, DIV_LAT);
            check_val("mfhi_rdata", rdata, dv_hi[i]);
            tick();
            op = OP_MFLO;
            @(negedge clk);
            check_val("mflo_after_div_stall", md_stall, 1'b0);
            check_val("mflo_after_div_rdata", rdata, dv_lo[i]);
            tick();
            op_valid = 1'b0;
        end

        // MTHI / MTLO followed by reads
        tick();
        op_valid = 1'b1; op = OP_MTHI; rs_val = 32'h0000_1234;
        @(negedge clk);
        check_val("mthi_stall", md_stall, 1'b0);
        tick();
        op = OP_MFHI; rs_val = 32'd0;
        @(negedge clk);
        check_val("mfhi_next_stall", md_stall, 1'b0);
        check_val("mfhi_next_rdata", rdata, 32'h0000_1234);
        tick();
        op = OP_MTLO; rs_val = 32'hA5A5_0001;
        tick();
        op = OP_MFLO; rs_val = 32'd0;
        @(negedge clk);
        check_val("mflo_next_rdata", rdata, 32'hA5A5_0001);
        tick();
        op = OP_MFHI;
        @(negedge clk);
        check_val("mfhi_kept_rdata", rdata, 32'h0000_1234);
        tick();
        op = OP_NOP;
        @(negedge clk);
        check_val("nop_rdata", rdata, 32'd0);
        tick();
        op = OP_RSVD; rs_val = 32'hDEAD_BEEF;
        @(negedge clk);
        check_val("rsvd_rdata", rdata, 32'd0);
        check_val("rsvd_mul_start", mul_start, 1'b0);
        check_val("rsvd_div_start", div_start, 1'b0);

        // MULT 3*5 with four cycles of ext_stall mid-operation
        tick();
        op = OP_MULT; rs_val = 32'd3; rt_val = 32'd5; ext_stall = 1'b1;
        @(negedge clk);
        check_val("start_blocked_ext_stall", mul_start, 1'b0);
        tick();
        ext_stall = 1'b0;
        sb.push_back('{1'b0, 32'd0, 32'd15});
        @(negedge clk);
        check_val("mul_start_after_stall", mul_start, 1'b1);
        k = 0; fin_k = 0;
        while (fin_k == 0 && k < 100) begin
            k++;
            tick();
            op_valid = 1'b0;
            ext_stall = (k >= 10 && k <= 13);
            @(negedge clk);
            if (k >= 9 && k <= 14) check_val("mul_hold_follows", mul_hold, ext_stall);
            if (mul_finish) fin_k = k;
        end
        check_val("held_mul_latency", fin_k, 32'd36);
        tick();
        ext_stall = 1'b0;

        // MULT immediately followed by DIV
        tick();
        op_valid = 1'b1; op = OP_MULT; rs_val = 32'hFFFF_FFFE; rt_val = 32'h4000_0000;
        sb.push_back('{1'b0, 32'hFFFF_FFFF, 32'h8000_0000});
        tick();
        op = OP_DIV; rs_val = 32'd50; rt_val = 32'hFFFF_FFFD;
        sb.push_back('{1'b1, 32'd2, 32'hFFFF_FFF0});
        ds_cnt = 0; ds_k = 0; ms_cnt = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (div_start) begin
                ds_cnt++;
                if (ds_k == 0) begin
                    ds_k = c;
                    check_val("b2b_div_a", div_a, 32'd50);
                    check_val("b2b_div_b", div_b, 32'hFFFF_FFFD);
                end
            end
            if (mul_start) ms_cnt++;
            tick();
            if (ds_k != 0) op_valid = 1'b0;
        end
        check_val("b2b_div_start_cycle", ds_k, 32'd33);
        check_val("b2b_div_start_count", ds_cnt, 32'd1);
        check_val("b2b_no_mul_restart", ms_cnt, 32'd0);
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            tick();
            n++;
        end
        tick();

        // Reset ten cycles into a MULT; the late finish must be ignored
        tick();
        op_valid = 1'b1; op = OP_MULT; rs_val = 32'd9; rt_val = 32'd9;
        @(negedge clk);
        check_val("rst_mul_start", mul_start, 1'b1);
        tick();
        op_valid = 1'b0;
        repeat (9) tick();
        op_valid = 1'b1; op = OP_MFLO;
        #2;
        reset = 1'b1;
        @(negedge clk);
        check_val("midop_rst_md_stall", md_stall, 1'b0);
        check_val("midop_rst_hi", hi, 32'd0);
        check_val("midop_rst_lo", lo, 32'd0);
        tick();
        reset = 1'b0;
        n = 0; fin = 1'b0; stalls = 0;
        while (!fin && n < 60) begin
            @(negedge clk);
            n++;
            if (md_stall) stalls++;
            if (mul_finish) fin = 1'b1;
            else            tick();
        end
        check_val("late_finish_seen", fin, 1'b1);
        check_val("post_rst_stalls", stalls, 32'd0);
        tick();
        @(negedge clk);
        check_val("late_finish_hi", hi, 32'd0);
        check_val("late_finish_lo", lo, 32'd0);
        check_val("late_finish_md_stall", md_stall, 1'b0);
        check_val("late_finish_rdata", rdata, 32'd0);

        tick();
        op_valid = 1'b0;
        check_val("scoreboard_drained", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
